sample_strobe_sync: RTL and testbench

SAMPLE_STROBE_SYNC -- requirements
Module: sample_strobe_sync

---
 rtl/sample_strobe_sync.sv | 174 +++++++++++++++++
 tb/tb_sample_strobe_sync.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_strobe_sync.sv
// ---------------------------------------------------------------------------
// sample_strobe_sync
//
// Brings N_CH asynchronous sample clocks (e.g. 48 kHz word clocks) into the
// clk_fast domain. Each channel is synchronised, glitch filtered and edge
// detected into a single-cycle strobe. A small per-channel FSM measures the
// strobe-to-strobe period and flags channels whose sample clock has stopped.
//
// Ports
//   clk_fast      in   1            system clock, all logic on rising edge
//   rst           in   1            asynchronous active-high reset
//   async_in      in   N_CH         asynchronous sample clocks, bit i = ch i
//   edge_sel      in   2*N_CH       per-channel mode [2i+1:2i]:
//                                   00 rising, 01 falling, 10 both, 11 off
//   strobe        out  N_CH         single-cycle event pulse per channel
//   period        out  N_CH*CNT_W   last measured interval, field i =
//                                   [CNT_W*(i+1)-1:CNT_W*i]
//   period_valid  out  N_CH         pulse marking a freshly updated period
//   timeout       out  N_CH         high while the channel is timed out
// ---------------------------------------------------------------------------
module sample_strobe_sync #(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    input  logic [N_CH-1:0]         async_in,
    input  logic [2*N_CH-1:0]       edge_sel,
    output logic [N_CH-1:0]         strobe,
    output logic [N_CH*CNT_W-1:0]   period,
    output logic [N_CH-1:0]         period_valid,
    output logic [N_CH-1:0]         timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TMO  = 2'd2;

    // The stability counter only ever needs to reach FILTER_LEN-1.
    localparam int STAB_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam longint unsigned   CNT_MAX     = (64'd1 << CNT_W) - 64'd1;

    // Reject parameter sets that would make the counter wrap or the
    // synchroniser/filter degenerate.
    if (N_CH < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1 || CNT_W < 2 ||
        TIMEOUT < 2 || 64'(TIMEOUT) > CNT_MAX) begin : g_param_check
        $error("sample_strobe_sync: illegal parameter combination");
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   synced;
        logic                   filt;
        logic [STAB_W-1:0]      stab;
        logic                   strobe_q;
        logic                   edge_hit;
        logic                   enabled;
        logic                   strobe_int;
        logic [1:0]             mode;
        logic [1:0]             state;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       cnt_inc;
        logic [CNT_W-1:0]       period_q;
        logic                   pv_q;

        assign mode    = edge_sel[2*ch +: 2];
        assign enabled = (mode != 2'b11);
        assign synced  = sync_q[SYNC_STAGES-1];
        assign cnt_inc = cnt + CNT_W'(1);

        // Whether accepting the new synced level counts as an event in the
        // current mode. Evaluated at the accepting edge, so a mode change is
        // honoured from the very next cycle.
        always_comb begin
            edge_hit = 1'b0;
            case (mode)
                2'b00:   edge_hit = synced;
                2'b01:   edge_hit = ~synced;
                2'b10:   edge_hit = 1'b1;
                default: edge_hit = 1'b0;
            endcase
        end

        // Synchroniser and glitch filter. These keep tracking the input even
        // when the channel is disabled, so re-enabling cannot see a stale
        // level difference and fire a spurious strobe. The strobe is
        // registered on the same edge that updates the filtered level, which
        // keeps the latency at SYNC_STAGES+FILTER_LEN edges.
        always_ff @(posedge clk_fast or posedge rst) begin
            if (rst) begin
                sync_q   <= '0;
                filt     <= 1'b0;
                stab     <= '0;
                strobe_q <= 1'b0;
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in[ch]};
                strobe_q <= 1'b0;
                if (synced == filt) begin
                    stab <= '0;
                end else if (stab == STAB_LAST) begin
                    filt     <= synced;
                    stab     <= '0;
                    strobe_q <= edge_hit;
                end else begin
                    stab <= stab + STAB_W'(1);
                end
            end
        end

        // Masking here as well covers a switch to mode 11 while a strobe is
        // already in the register.
        assign strobe_int = strobe_q & enabled;

        // Period measurement / timeout FSM. cnt tracks cycles since the last
        // strobe; the strobe cycle itself is included via cnt+1. A strobe
        // arriving on the very cycle the timeout limit is reached takes
        // priority and is treated as a normal measurement.
        always_ff @(posedge clk_fast or posedge rst) begin
            if (rst) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                period_q <= '0;
                pv_q     <= 1'b0;
            end else begin
                pv_q <= 1'b0;
                if (!enabled) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            cnt <= '0;
                            if (strobe_int) begin
                                state <= ST_RUN;
                            end
                        end
                        ST_RUN: begin
                            if (strobe_int) begin
                                period_q <= cnt_inc;
                                pv_q     <= 1'b1;
                                cnt      <= '0;
                            end else if (cnt_inc == TIMEOUT_CNT) begin
                                state <= ST_TMO;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        ST_TMO: begin
                            if (strobe_int) begin
                                state <= ST_RUN;
                                cnt   <= '0;
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign strobe[ch]                 = strobe_int;
        assign period_valid[ch]           = pv_q & enabled;
        assign timeout[ch]                = (state == ST_TMO) & enabled;
        assign period[CNT_W*ch +: CNT_W]  = period_q;
    end

endmodule

// File: tb/tb_sample_strobe_sync.sv
// ---------------------------------------------------------------------------
// tb_sample_strobe_sync
//
// Directed bench for sample_strobe_sync at default parameters. Stimulus
// drives async_in on falling edges and pushes every output event it expects
// (strobe, period_valid with its period value, timeout rise/fall) with the
// cycle number it must appear on into a per-channel queue. An independent
// monitor watches the outputs on falling edges and pops one entry for each
// event it sees; anything unexpected, late, early or left over is reported.
// ---------------------------------------------------------------------------
module tb_sample_strobe_sync;

    localparam int EV_STB = 0;
    localparam int EV_PV  = 1;
    localparam int EV_TR  = 2;
    localparam int EV_TF  = 3;

    typedef struct {
        int kind;
        int cyc;
        int per;
    } ev_t;

    logic        clk_fast;
    logic        rst;
    logic [1:0]  async_in;
    logic [3:0]  edge_sel;
    logic [1:0]  strobe;
    logic [31:0] period;
    logic [1:0]  period_valid;
    logic [1:0]  timeout;

    int   cycle_cnt   = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    ev_t  q0[$];
    ev_t  q1[$];
    logic [1:0] prev_tmo = 2'b00;

    sample_strobe_sync dut (
        .clk_fast     (clk_fast),
        .rst          (rst),
        .async_in     (async_in),
        .edge_sel     (edge_sel),
        .strobe       (strobe),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    initial begin
        clk_fast = 1'b0;
        forever #5 clk_fast = ~clk_fast;
    end

    always @(posedge clk_fast) cycle_cnt <= cycle_cnt + 1;

    function automatic string kind_name(int k);
        case (k)
            EV_STB:  return "strobe";
            EV_PV:   return "period_valid";
            EV_TR:   return "timeout_rise";
            EV_TF:   return "timeout_fall";
            default: return "none";
        endcase
    endfunction

    task automatic push_ev(int ch, int kind, int cyc, int per);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.per  = per;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Monitor side: match one observed event against the queue head.
    task automatic score(int ch, int kind);
        ev_t e;
        int  have;
        int  act_per;
        vectors++;
        have    = (ch == 0) ? q0.size() : q1.size();
        act_per = int'(period[16*ch +: 16]);
        if (have == 0) begin
            miscompares++;
            $display("[TB] FAIL ch%0d unexpected_event: got %s at cycle %0d, required no event",
                     ch, kind_name(kind), cycle_cnt);
            return;
        end
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        if (e.kind != kind || e.cyc != cycle_cnt ||
            (kind == EV_PV && e.per != act_per)) begin
            miscompares++;
            $display("[TB] FAIL ch%0d event: got %s at cycle %0d period %0d, required %s at cycle %0d period %0d",
                     ch, kind_name(kind), cycle_cnt, act_per,
                     kind_name(e.kind), e.cyc, e.per);
        end
    endtask

    // Observe outputs half a cycle after the active edge.
    always @(negedge clk_fast) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (strobe[ch])                    score(ch, EV_STB);
            if (period_valid[ch])              score(ch, EV_PV);
            if (timeout[ch] && !prev_tmo[ch])  score(ch, EV_TR);
            if (!timeout[ch] && prev_tmo[ch])  score(ch, EV_TF);
            prev_tmo[ch] = timeout[ch];
        end
    end

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(int ch, logic level);
        async_in[ch] = level;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk_fast);
    endtask

    task automatic goto_cycle(int c);
        while (cycle_cnt < c) @(negedge clk_fast);
    endtask

    task automatic check_quiet_outputs(string tag);
        checkOutput({tag, "_strobe"},       64'(strobe),       64'd0);
        checkOutput({tag, "_period_valid"}, 64'(period_valid), 64'd0);
        checkOutput({tag, "_timeout"},      64'(timeout),      64'd0);
        checkOutput({tag, "_period"},       64'(period),       64'd0);
    endtask

    initial begin
        int c;
        int base;
        int s0;
        async_in = 2'b00;
        edge_sel = 4'b1100;
        rst      = 1'b0;
        #2 rst   = 1'b1;
        wait_cycles(3);
        check_quiet_outputs("reset");
        rst = 1'b0;
        wait_cycles(5);

        $display("[TB] glitch rejection and first strobe");
        applyStimulus(0, 1'b1);
        wait_cycles(2);
        applyStimulus(0, 1'b0);
        wait_cycles(12);
        c = cycle_cnt;
        applyStimulus(0, 1'b1);
        push_ev(0, EV_STB, c + 5, 0);
        wait_cycles(3);
        applyStimulus(0, 1'b0);
        base = c;

        $display("[TB] periodic rising edges every 2083 cycles");
        for (int k = 1; k <= 3; k++) begin
            goto_cycle(base + 2083 * k);
            c = cycle_cnt;
            applyStimulus(0, 1'b1);
            push_ev(0, EV_STB, c + 5, 0);
            push_ev(0, EV_PV,  c + 6, 2083);
            wait_cycles(1000);
            applyStimulus(0, 1'b0);
        end
        s0 = base + 3 * 2083 + 5;

        $display("[TB] strobe on the timeout cycle");
        goto_cycle(s0 + 4091);
        applyStimulus(0, 1'b1);
        push_ev(0, EV_STB, s0 + 4096, 0);
        push_ev(0, EV_PV,  s0 + 4097, 4096);
        wait_cycles(1000);
        applyStimulus(0, 1'b0);
        s0 = s0 + 4096;

        $display("[TB] timeout and recovery");
        push_ev(0, EV_TR, s0 + 4097, 0);
        goto_cycle(s0 + 4200);
        c = cycle_cnt;
        applyStimulus(0, 1'b1);
        push_ev(0, EV_STB, c + 5, 0);
        push_ev(0, EV_TF,  c + 6, 0);
        wait_cycles(500);
        applyStimulus(0, 1'b0);
        goto_cycle(c + 1500);
        applyStimulus(0, 1'b1);
        push_ev(0, EV_STB, c + 1505, 0);
        push_ev(0, EV_PV,  c + 1506, 1500);
        wait_cycles(500);
        applyStimulus(0, 1'b0);
        s0 = c + 1505;

        $display("[TB] ch1 disabled with active input, ch0 keeps running");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, ~async_in[1]);
            if (k == 2) begin
                c = cycle_cnt;
                applyStimulus(0, 1'b1);
                push_ev(0, EV_STB, c + 5, 0);
                push_ev(0, EV_PV,  c + 6, c + 5 - s0);
                s0 = c + 5;
            end
            if (k == 3) applyStimulus(0, 1'b0);
            wait_cycles(150);
        end
        wait_cycles(50);

        $display("[TB] ch1 both-edge square wave, simultaneous ch0 edges");
        edge_sel[3:2] = 2'b10;
        wait_cycles(20);
        for (int k = 0; k < 6; k++) begin
            c = cycle_cnt;
            applyStimulus(1, ~async_in[1]);
            push_ev(1, EV_STB, c + 5, 0);
            if (k > 0) push_ev(1, EV_PV, c + 6, 1000);
            if (k % 2 == 1) begin
                applyStimulus(0, 1'b1);
                push_ev(0, EV_STB, c + 5, 0);
                push_ev(0, EV_PV,  c + 6, c + 5 - s0);
                s0 = c + 5;
            end else begin
                applyStimulus(0, 1'b0);
            end
            wait_cycles(1000);
        end
        applyStimulus(0, 1'b0);
        wait_cycles(10);

        $display("[TB] reset in the middle of filtering");
        applyStimulus(0, 1'b1);
        wait_cycles(3);
        rst = 1'b1;
        #1;
        check_quiet_outputs("mid_reset");
        wait_cycles(3);
        check_quiet_outputs("held_reset");
        rst = 1'b0;
        c = cycle_cnt;
        push_ev(0, EV_STB, c + 5, 0);
        push_ev(1, EV_STB, c + 5, 0);
        wait_cycles(30);

        vectors++;
        if (q0.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ch0 missing_events: got %0d left over, required 0", q0.size());
        end
        vectors++;
        if (q1.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL ch1 missing_events: got %0d left over, required 0", q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
